fp_mul_pack_round: RTL and testbench

Back end of the FP32 multiplier: accepts the 48-bit product of the two normalized 24-bit mantissas plus the operand exponent fields, leading-zero shift counts and sign produced by the multiply front-end normalizer. Re-normalizes, iteratively denormalizes tiny results, rounds to nearest-even and packs an IEEE-754 single. Multi-cycle FSM with valid/ready on both sides; sits between the mantissa multiplier and the FPU result mux.

---
 rtl/fp32_mul_pkg.sv | 29 ++
 rtl/fp_mul_rne.sv | 26 ++
 rtl/fp_mul_pack_round.sv | 275 +++++++++++++++++++++++++++
 tb/tb_fp_mul_pack_round.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fp32_mul_pkg.sv
// -----------------------------------------------------------------------------
// fp32_mul_pkg
//   Shared constants and types for the FP32 multiplier back end
//   (fp_mul_pack_round and its rounding incrementer fp_mul_rne).
//   Contents:
//     BIAS, EXP_FIELD_MAX, QNAN  - IEEE-754 single constants
//     EXP_W_DEF, SHIFT_CAP_DEF   - default internal exponent width and
//                                  maximum denormalization shift count
//     state_e                    - back-end FSM states
// -----------------------------------------------------------------------------
package fp32_mul_pkg;

  localparam int          BIAS          = 127;
  localparam int          EXP_FIELD_MAX = 255;
  localparam logic [31:0] QNAN          = 32'h7FC0_0000;

  // 10 signed bits cover the full internal range -171..382.
  localparam int EXP_W_DEF     = 10;
  localparam int SHIFT_CAP_DEF = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NORM,
    ST_DENORM,
    ST_ROUND,
    ST_OUT
  } state_e;

endpackage : fp32_mul_pkg

// File: rtl/fp_mul_rne.sv
// -----------------------------------------------------------------------------
// fp_mul_rne
//   Combinational round-to-nearest-even incrementer.
//   Ports:
//     m        in  24  mantissa including hidden bit
//     g        in  1   guard bit (first bit below m)
//     s        in  1   sticky (OR of everything below g)
//     m25      out 25  rounded mantissa; bit 24 is the carry-out
//     inexact  out 1   any discarded bit was non-zero
// -----------------------------------------------------------------------------
module fp_mul_rne (
  input  logic [23:0] m,
  input  logic        g,
  input  logic        s,
  output logic [24:0] m25,
  output logic        inexact
);

  logic round_up;

  // Round up above the halfway point, or exactly at it when m is odd.
  assign round_up = g & (s | m[0]);
  assign m25      = {1'b0, m} + {24'b0, round_up};
  assign inexact  = g | s;

endmodule : fp_mul_rne

// File: rtl/fp_mul_pack_round.sv
// -----------------------------------------------------------------------------
// fp_mul_pack_round
//   Back end of the FP32 multiplier. Takes the 48-bit mantissa product and
//   the operand exponent data, re-normalizes, denormalizes tiny results one
//   bit per cycle, rounds to nearest-even and packs an IEEE-754 single.
//
//   Configuration macro: FP_MUL_FTZ_EN
//     defined   - tiny results flush to signed zero (underflow+inexact),
//                 no DENORM state logic is built.
//     undefined - gradual underflow through the DENORM state.
//
//   Ports:
//     clk, rst_n                  clock, synchronous active-low reset
//     in_valid / in_ready         input handshake (ready only in IDLE)
//     in_prod[47:0]               mantissa product, point between 46 and 45
//     in_exp1/2[7:0]              raw biased exponent fields
//     in_shift1/2[4:0]            front-end leading-zero shift counts
//     in_sign, in_nan, in_inf     sign and upstream special classification
//     out_valid / out_ready       output handshake (held until accepted)
//     out_result[31:0]            packed FP32 result
//     out_overflow/underflow/inexact  exception flags
// -----------------------------------------------------------------------------
module fp_mul_pack_round
  import fp32_mul_pkg::*;
#(
  parameter int EXP_W     = EXP_W_DEF,
  parameter int SHIFT_CAP = SHIFT_CAP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_prod,
  input  logic [7:0]  in_exp1,
  input  logic [7:0]  in_exp2,
  input  logic [4:0]  in_shift1,
  input  logic [4:0]  in_shift2,
  input  logic        in_sign,
  input  logic        in_nan,
  input  logic        in_inf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact
);

  localparam logic signed [EXP_W-1:0] E_ONE       = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] E_FIELD_MAX = EXP_W'(EXP_FIELD_MAX);
`ifndef FP_MUL_FTZ_EN
  // Below this exponent every mantissa bit would be shifted into sticky.
  localparam logic signed [EXP_W-1:0] E_COLLAPSE  = EXP_W'(1 - SHIFT_CAP);
`endif

  // Control / result state
  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        inx_q, inx_d;

  // Captured operand bundle
  logic [47:0] prod_q, prod_d;
  logic [7:0]  exp1_q, exp1_d, exp2_q, exp2_d;
  logic [4:0]  shift1_q, shift1_d, shift2_q, shift2_d;
  logic        sign_q, sign_d, nan_q, nan_d, inf_q, inf_d;

  // Working mantissa / exponent
  logic [23:0]             m_q, m_d;
  logic                    g_q, g_d, s_q, s_d;
  logic signed [EXP_W-1:0] e_q, e_d;

  // NORM-stage datapath
  logic [7:0]              eeff1, eeff2;
  logic signed [EXP_W-1:0] e_base, e_norm;
  logic [23:0]             m_norm;
  logic                    g_norm, s_norm;

  // ROUND-stage datapath
  logic [24:0]             m25;
  logic                    rne_inexact;
  logic [23:0]             m_rnd;
  logic signed [EXP_W-1:0] e_rnd;
  logic [7:0]              field_rnd;

  // A zero exponent field means a subnormal operand whose effective
  // exponent is 1; the front end already counted its leading zeros.
  always_comb begin
    eeff1  = (exp1_q == 8'd0) ? 8'd1 : exp1_q;
    eeff2  = (exp2_q == 8'd0) ? 8'd1 : exp2_q;
    e_base = EXP_W'(eeff1) + EXP_W'(eeff2) - EXP_W'(BIAS)
           - EXP_W'(shift1_q) - EXP_W'(shift2_q);
    if (prod_q[47]) begin
      m_norm = prod_q[47:24];
      g_norm = prod_q[23];
      s_norm = |prod_q[22:0];
      e_norm = e_base + E_ONE;
    end else begin
      m_norm = prod_q[46:23];
      g_norm = prod_q[22];
      s_norm = |prod_q[21:0];
      e_norm = e_base;
    end
  end

  fp_mul_rne u_rne (
    .m       (m_q),
    .g       (g_q),
    .s       (s_q),
    .m25     (m25),
    .inexact (rne_inexact)
  );

  // Carry out of rounding renormalizes; a subnormal that rounds up into
  // bit 23 picks up exponent 1 naturally since e_q is already 1.
  always_comb begin
    if (m25[24]) begin
      m_rnd = m25[24:1];
      e_rnd = e_q + E_ONE;
    end else begin
      m_rnd = m25[23:0];
      e_rnd = e_q;
    end
    field_rnd = m_rnd[23] ? e_rnd[7:0] : 8'd0;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;
    prod_d   = prod_q;
    exp1_d   = exp1_q;
    exp2_d   = exp2_q;
    shift1_d = shift1_q;
    shift2_d = shift2_q;
    sign_d   = sign_q;
    nan_d    = nan_q;
    inf_d    = inf_q;
    m_d      = m_q;
    g_d      = g_q;
    s_d      = s_q;
    e_d      = e_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          prod_d   = in_prod;
          exp1_d   = in_exp1;
          exp2_d   = in_exp2;
          shift1_d = in_shift1;
          shift2_d = in_shift2;
          sign_d   = in_sign;
          nan_d    = in_nan;
          inf_d    = in_inf;
          state_d  = ST_NORM;
        end
      end

      ST_NORM: begin
        m_d = m_norm;
        g_d = g_norm;
        s_d = s_norm;
        e_d = e_norm;
        if (nan_q) begin
          result_d = QNAN;
          {ovf_d, unf_d, inx_d} = 3'b000;
          state_d  = ST_OUT;
        end else if (inf_q) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          {ovf_d, unf_d, inx_d} = 3'b000;
          state_d  = ST_OUT;
        end else if (prod_q == 48'd0) begin
          result_d = {sign_q, 31'd0};
          {ovf_d, unf_d, inx_d} = 3'b000;
          state_d  = ST_OUT;
`ifdef FP_MUL_FTZ_EN
        end else if (e_norm < E_ONE) begin
          result_d = {sign_q, 31'd0};
          {ovf_d, unf_d, inx_d} = 3'b011;
          state_d  = ST_OUT;
`else
        end else if (e_norm < E_COLLAPSE) begin
          m_d     = 24'd0;
          g_d     = 1'b0;
          s_d     = 1'b1;
          e_d     = E_ONE;
          state_d = ST_ROUND;
        end else if (e_norm < E_ONE) begin
          state_d = ST_DENORM;
`endif
        end else begin
          state_d = ST_ROUND;
        end
      end

`ifndef FP_MUL_FTZ_EN
      ST_DENORM: begin
        m_d = {1'b0, m_q[23:1]};
        g_d = m_q[0];
        s_d = s_q | g_q;
        e_d = e_q + E_ONE;
        if (e_q == '0) state_d = ST_ROUND;
      end
`endif

      ST_ROUND: begin
        if (e_rnd >= E_FIELD_MAX) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          {ovf_d, unf_d, inx_d} = 3'b101;
        end else begin
          result_d = {sign_q, field_rnd, m_rnd[22:0]};
          ovf_d    = 1'b0;
          inx_d    = rne_inexact;
          // Tininess is judged on the unrounded mantissa.
          unf_d    = rne_inexact & ~m_q[23];
        end
        state_d = ST_OUT;
      end

      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its _d regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= 32'd0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  // NOTE: datapath registers are left without reset; each is written in
  // IDLE or NORM before any state reads it.
  always_ff @(posedge clk) begin
    prod_q   <= prod_d;
    exp1_q   <= exp1_d;
    exp2_q   <= exp2_d;
    shift1_q <= shift1_d;
    shift2_q <= shift2_d;
    sign_q   <= sign_d;
    nan_q    <= nan_d;
    inf_q    <= inf_d;
    m_q      <= m_d;
    g_q      <= g_d;
    s_q      <= s_d;
    e_q      <= e_d;
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = (state_q == ST_OUT);
  assign out_result    = result_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_inexact   = inx_q;

endmodule : fp_mul_pack_round

// File: tb/tb_fp_mul_pack_round.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_pack_round
//   Directed vectors with hand-computed results for fp_mul_pack_round.
//   Latency is counted in cycles after the accepting edge; flags are packed
//   as {overflow, underflow, inexact}. With FP_MUL_FTZ_EN defined, tiny
//   vectors expect a flushed signed zero two cycles after accept.
// -----------------------------------------------------------------------------
module tb_fp_mul_pack_round;

`ifdef FP_MUL_FTZ_EN
  localparam bit FTZ = 1'b1;
`else
  localparam bit FTZ = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_prod;
  logic [7:0]  in_exp1, in_exp2;
  logic [4:0]  in_shift1, in_shift2;
  logic        in_sign, in_nan, in_inf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow, out_underflow, out_inexact;

  int n_cmp = 0;
  int n_err = 0;

  fp_mul_pack_round dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_prod       (in_prod),
    .in_exp1       (in_exp1),
    .in_exp2       (in_exp2),
    .in_shift1     (in_shift1),
    .in_shift2     (in_shift2),
    .in_sign       (in_sign),
    .in_nan        (in_nan),
    .in_inf        (in_inf),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, out_overflow, out_underflow, out_inexact};
  endfunction

  // Drive one operand bundle, wait for the result, check it, optionally
  // stall the consumer for hold cycles, then complete the handshake.
  task automatic run_op(input string tag, input logic [47:0] prod,
                        input logic [7:0] e1, input logic [7:0] e2,
                        input logic [4:0] sh1, input logic [4:0] sh2,
                        input logic sign, input logic nan, input logic inf,
                        input logic [31:0] exp_res, input logic [2:0] exp_flg,
                        input int exp_lat, input bit tiny, input int hold);
    int cycles;
    logic [31:0] want_res;
    logic [2:0]  want_flg;
    int          want_lat;
    want_res = exp_res;
    want_flg = exp_flg;
    want_lat = exp_lat;
    if (FTZ && tiny) begin
      want_res = {sign, 31'd0};
      want_flg = 3'b011;
      want_lat = 2;
    end

    @(negedge clk);
    out_ready = (hold == 0);
    in_prod   = prod;
    in_exp1   = e1;
    in_exp2   = e2;
    in_shift1 = sh1;
    in_shift2 = sh2;
    in_sign   = sign;
    in_nan    = nan;
    in_inf    = inf;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;

    cycles = 0;
    while (cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (out_valid) break;
    end
    check({tag, "_lat"},   32'(cycles), 32'(want_lat));
    check({tag, "_res"},   out_result, want_res);
    check({tag, "_flags"}, flags(), {29'd0, want_flg});

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_res"},   out_result, want_res);
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
    end

    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_done_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_exp1   = '0;
    in_exp2   = '0;
    in_shift1 = '0;
    in_shift2 = '0;
    in_sign   = 1'b0;
    in_nan    = 1'b0;
    in_inf    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result",    out_result, 32'd0);
    check("rst_flags",     flags(), 32'd0);

    //     tag            prod              e1     e2     sh1   sh2   s     nan   inf   result         {o,u,i} lat tiny hold
    run_op("mul_1p5x2",   48'h6000_0000_0000, 8'd127, 8'd128, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h4040_0000, 3'b000, 3,  0, 0);
    // (2^23+1)^2 = 2^46 + 2^24 + 1
    run_op("sq_1ulp",     48'h4000_0100_0001, 8'd127, 8'd127, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 3'b001, 3,  0, 0);
    run_op("ovf",         48'h4000_0000_0000, 8'd254, 8'd254, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b101, 3,  0, 0);
    run_op("denorm_half", 48'h4000_0000_0000, 8'd1,   8'd126, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 3'b000, 4,  1, 0);
    run_op("nan_hold",    48'h4000_0000_0000, 8'd127, 8'd127, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h7FC0_0000, 3'b000, 2,  0, 5);
    run_op("inf_neg",     48'h4000_0000_0000, 8'd127, 8'd127, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'hFF80_0000, 3'b000, 2,  0, 0);
    run_op("zero_neg",    48'h0000_0000_0000, 8'd127, 8'd127, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 3'b000, 2,  0, 0);
    run_op("tie_even",    48'h4000_0080_0000, 8'd1,   8'd126, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 3'b011, 4,  1, 0);
    run_op("dn_round_up", 48'h4000_0180_0000, 8'd1,   8'd126, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0040_0002, 3'b011, 4,  1, 0);
    run_op("dn_to_norm",  48'h7FFF_FF80_0000, 8'd1,   8'd126, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0080_0000, 3'b011, 4,  1, 0);
    run_op("carry_norm",  48'h7FFF_FFC0_0000, 8'd127, 8'd127, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 3'b001, 3,  0, 0);
    run_op("ovf_carry",   48'h7FFF_FFC0_0000, 8'd254, 8'd127, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b101, 3,  0, 0);
    run_op("subnorm_op",  48'h4000_0000_0000, 8'd0,   8'd254, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b000, 3,  0, 0);
    run_op("dn_shift3",   48'h6000_0000_0000, 8'd1,   8'd124, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0018_0000, 3'b000, 6,  1, 0);
    // E = -25: exactly the maximum 26 denormalization shifts
    run_op("dn_max",      48'h4000_0000_0000, 8'd1,   8'd101, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b011, 29, 1, 0);
    // E = -26: one past the cap, collapses to sticky and goes straight to ROUND
    run_op("collapse",    48'h4000_0000_0000, 8'd1,   8'd100, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 3'b011, 3,  1, 0);

    // Reset in the middle of a 17-shift denormalization.
    @(negedge clk);
    in_prod   = 48'h4000_0000_0000;
    in_exp1   = 8'd1;
    in_exp2   = 8'd110;
    in_shift1 = 5'd0;
    in_shift2 = 5'd0;
    in_sign   = 1'b0;
    in_nan    = 1'b0;
    in_inf    = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result",    out_result, 32'd0);
    rst_n = 1'b1;
    run_op("after_rst",   48'h6000_0000_0000, 8'd127, 8'd128, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h4040_0000, 3'b000, 3,  0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fp_mul_pack_round
